vga_plot_arbiter: RTL

Parametrised arbiter that multiplexes several pixel-plot sources onto the single VGA adapter write port (plot/x/y/colour). It replaces the hard-wired two-phase source selection in the game top level, where init-screen drawing is followed by gameplay drawing. Sources request ownership and receive an exclusive grant. A granted source owns the port until it releases or its hold budget expires. Plot outputs are registered, with optional off-screen clipping.

---
 rtl/vga_plot_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/vga_plot_arbiter.sv
// Exclusive-ownership arbiter for the VGA adapter write port, with registered plot outputs.
// Define VGA_ARB_CLIP_EN to drop and count plots that fall outside X_MAX/Y_MAX.
//
// state | meaning
// IDLE  | no owner; pick a winner from src_req
// GRANT | owner's plots are forwarded to vga_*
// GAP   | one dead cycle after release before re-arbitration
module vga_plot_arbiter #(
  parameter int NUM_SRC  = 2,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3,
  parameter int X_MAX    = 159,
  parameter int Y_MAX    = 119,
  parameter int RR_MODE  = 0,
  parameter int MAX_HOLD = 0
) (
  input  logic                   CLOCK_50,
  input  logic                   rst_n,
  input  logic [NUM_SRC-1:0]     src_req,
  input  logic [NUM_SRC-1:0]     src_plot,
  input  logic [NUM_SRC*X_W-1:0] src_x,
  input  logic [NUM_SRC*Y_W-1:0] src_y,
  input  logic [NUM_SRC*C_W-1:0] src_colour,
  output logic [NUM_SRC-1:0]     src_grant,
  output logic                   vga_plot,
  output logic [X_W-1:0]         vga_x,
  output logic [Y_W-1:0]         vga_y,
  output logic [C_W-1:0]         vga_colour,
  output logic [2:0]             owner,
  output logic                   busy,
  output logic [7:0]             clip_drops
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);
`ifdef VGA_ARB_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  state_t state, state_nx;
  logic [2:0]         last_owner;
  logic [15:0]        hold_cnt;
  logic [15:0]        hold_nx;
  logic [2:0]         winner;
  logic [NUM_SRC-1:0] grant_nx;
  logic               any_req;
  logic               found;
  logic               own_req;
  logic               own_plot;
  logic [X_W-1:0]     own_x;
  logic [Y_W-1:0]     own_y;
  logic [C_W-1:0]     own_colour;
  logic               off_screen;
  logic               release_now;
  logic               fwd;

  always_comb begin
    own_req    = 1'b0;
    own_plot   = 1'b0;
    own_x      = '0;
    own_y      = '0;
    own_colour = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (owner == 3'(i)) begin
        own_req    = src_req[i];
        own_plot   = src_plot[i];
        own_x      = src_x[i*X_W +: X_W];
        own_y      = src_y[i*Y_W +: Y_W];
        own_colour = src_colour[i*C_W +: C_W];
      end
    end
  end

  // Round-robin scans from the source after the last owner, wrapping at NUM_SRC.
  always_comb begin
    winner  = '0;
    found   = 1'b0;
    any_req = |src_req;
    if (RR_MODE == 0) begin
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
        if (src_req[i]) winner = 3'(i);
      end
    end else begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        for (int j = 0; j < NUM_SRC; j++) begin
          if (!found && j == (int'(last_owner) + k) % NUM_SRC && src_req[j]) begin
            winner = 3'(j);
            found  = 1'b1;
          end
        end
      end
    end
    for (int j = 0; j < NUM_SRC; j++) grant_nx[j] = (winner == 3'(j));
  end

  assign hold_nx     = hold_cnt + 16'd1;
  assign release_now = !own_req || (MAX_HOLD != 0 && hold_nx == 16'(MAX_HOLD));
  assign off_screen  = (own_x > X_LIM) || (own_y > Y_LIM);
  assign fwd         = (state == GRANT) && own_plot && !(CLIP_EN && off_screen);
  assign busy        = (state == GRANT);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = GRANT;
      GRANT:   if (release_now) state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state      <= IDLE;
      src_grant  <= '0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      owner      <= '0;
      hold_cnt   <= '0;
      last_owner <= 3'(NUM_SRC - 1);
    end else begin
      state    <= state_nx;
      vga_plot <= fwd;
      if (fwd) begin
        vga_x      <= own_x;
        vga_y      <= own_y;
        vga_colour <= own_colour;
      end
      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= winner;
            last_owner <= winner;
            src_grant  <= grant_nx;
            hold_cnt   <= '0;
          end
        end
        GRANT: begin
          if (MAX_HOLD != 0) hold_cnt <= hold_nx;
          if (release_now) src_grant <= '0;
        end
        default: src_grant <= '0;
      endcase
    end
  end

`ifdef VGA_ARB_CLIP_EN
  logic [7:0] drop_cnt;
  logic       drop;
  assign drop = (state == GRANT) && own_plot && off_screen;

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
  assign clip_drops = drop_cnt;
`else
  assign clip_drops = 8'd0;
`endif

endmodule
